// File: rtl/cmult_pkg.sv
// rtl/cmult_pkg.sv - shared constants, id sizing helper and tag type for cmult_share_arb
package cmult_pkg;
  localparam int AWIDTH_DEF   = 18;
  localparam int BWIDTH_DEF   = 18;
  localparam int NREQ_DEF     = 4;
  localparam int NREQ_MAX     = 8;
  localparam int MULT_LAT_DEF = 6;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int pwidth(input int aw, input int bw);
    return aw + bw + 1;
  endfunction

  // Tag ids are sized for the largest supported requester count.
  localparam int ID_W   = clog2(NREQ_MAX);
  localparam int PWIDTH = AWIDTH_DEF + BWIDTH_DEF + 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/cmult_share_arb_if.sv
// rtl/cmult_share_arb_if.sv - requester, multiplier and response signals of cmult_share_arb
interface cmult_share_arb_if
  import cmult_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int BWIDTH = BWIDTH_DEF,
  parameter int NREQ   = NREQ_DEF
);
  localparam int PW = pwidth(AWIDTH, BWIDTH);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*AWIDTH-1:0] req_ar;
  logic [NREQ*AWIDTH-1:0] req_ai;
  logic [NREQ*BWIDTH-1:0] req_br;
  logic [NREQ*BWIDTH-1:0] req_bi;
  logic [AWIDTH-1:0]      m_ar;
  logic [AWIDTH-1:0]      m_ai;
  logic [BWIDTH-1:0]      m_br;
  logic [BWIDTH-1:0]      m_bi;
  logic [PW-1:0]          m_pr;
  logic [PW-1:0]          m_pi;
  logic [NREQ-1:0]        rsp_valid;
  logic [PW-1:0]          rsp_pr;
  logic [PW-1:0]          rsp_pi;

  modport slave (
    input  req_valid, req_ar, req_ai, req_br, req_bi, m_pr, m_pi,
    output req_ready, m_ar, m_ai, m_br, m_bi, rsp_valid, rsp_pr, rsp_pi
  );

  modport master (
    output req_valid, req_ar, req_ai, req_br, req_bi, m_pr, m_pi,
    input  req_ready, m_ar, m_ai, m_br, m_bi, rsp_valid, rsp_pr, rsp_pi
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with a pointer that moves past each winner
module rr_arbiter
  import cmult_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;
  logic          found;

  // Scan N slots starting at the pointer; first requester seen wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
    grant = found ? (N'(1) << grant_idx) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/cmult_share_arb.sv
// rtl/cmult_share_arb.sv - shares one fixed-latency complex multiplier among NREQ requesters
module cmult_share_arb
  import cmult_pkg::*;
#(
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int BWIDTH   = BWIDTH_DEF,
  parameter int NREQ     = NREQ_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  cmult_share_arb_if.slave    bus,
  output logic                busy,
  output logic [31:0]         issue_cnt
);
  localparam int IW = clog2(NREQ);

  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              hs;
  logic [AWIDTH-1:0] m_ar_q, m_ar_d, m_ai_q, m_ai_d;
  logic [BWIDTH-1:0] m_br_q, m_br_d, m_bi_q, m_bi_d;
  logic [31:0]       issue_cnt_q, issue_cnt_d;
  tag_t              tag_q [MULT_LAT+1];
  tag_t              tag_d [MULT_LAT+1];
  tag_t              tag_out;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .advance   (hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;
  assign hs            = |(bus.req_valid & grant);

  // Idle cycles present zero operands so the multiplier sees no stale data.
  always_comb begin
    m_ar_d = '0;
    m_ai_d = '0;
    m_br_d = '0;
    m_bi_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        m_ar_d = bus.req_ar[i*AWIDTH +: AWIDTH];
        m_ai_d = bus.req_ai[i*AWIDTH +: AWIDTH];
        m_br_d = bus.req_br[i*BWIDTH +: BWIDTH];
        m_bi_d = bus.req_bi[i*BWIDTH +: BWIDTH];
      end
    end
  end

  // Stage 0 sits beside the operand register, so MULT_LAT further stages line up with m_pr/m_pi.
  always_comb begin
    tag_d[0].valid = hs;
    tag_d[0].id    = ID_W'(grant_idx);
    for (int s = 1; s <= MULT_LAT; s++) tag_d[s] = tag_q[s-1];
  end

  always_comb begin
    busy = hs;
    for (int s = 0; s <= MULT_LAT; s++) busy = busy | tag_q[s].valid;
  end

  assign issue_cnt_d = issue_cnt_q + 32'(hs);
  assign issue_cnt   = issue_cnt_q;
  assign tag_out     = tag_q[MULT_LAT];

  assign bus.m_ar      = m_ar_q;
  assign bus.m_ai      = m_ai_q;
  assign bus.m_br      = m_br_q;
  assign bus.m_bi      = m_bi_q;
  assign bus.rsp_valid = tag_out.valid ? (NREQ'(1) << tag_out.id) : '0;
  assign bus.rsp_pr    = bus.m_pr;
  assign bus.rsp_pi    = bus.m_pi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ar_q      <= '0;
      m_ai_q      <= '0;
      m_br_q      <= '0;
      m_bi_q      <= '0;
      issue_cnt_q <= '0;
      for (int s = 0; s <= MULT_LAT; s++) tag_q[s] <= '0;
    end else begin
      m_ar_q      <= m_ar_d;
      m_ai_q      <= m_ai_d;
      m_br_q      <= m_br_d;
      m_bi_q      <= m_bi_d;
      issue_cnt_q <= issue_cnt_d;
      for (int s = 0; s <= MULT_LAT; s++) tag_q[s] <= tag_d[s];
    end
  end
endmodule
